// File: rtl/chacha_pkg.sv
// Shared ChaCha types, geometry constants and word helpers.
package chacha_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned CHACHA_WORDS = 16;
    localparam int unsigned CHACHA_ROWS  = 4;
    localparam int unsigned IDX_W        = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [CHACHA_ROWS-1:0][CHACHA_ROWS-1:0] state_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = IDX_W'(CHACHA_WORDS - 1);

    function automatic word_t bswap32(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Row-major pick: word idx lives at [idx/4][idx%4].
    function automatic word_t state_word(input state_t s, input idx_t idx);
        return s[idx[3:2]][idx[1:0]];
    endfunction

endpackage

// File: rtl/chacha_block_serializer_if.sv
// Block-in / keystream-word-out handshake bundle for the block serializer.
interface chacha_block_serializer_if
    import chacha_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic             blk_valid;
    logic             blk_ready;
    state_t           blk_state;
    logic [CNT_W-1:0] blk_counter;
    logic             ks_valid;
    logic             ks_ready;
    word_t            ks_word;
    idx_t             ks_idx;
    logic             ks_last;
    logic [CNT_W-1:0] ks_counter;

    modport master (
        output blk_valid, blk_state, blk_counter, ks_ready,
        input  blk_ready, ks_valid, ks_word, ks_idx, ks_last, ks_counter
    );

    modport slave (
        input  blk_valid, blk_state, blk_counter, ks_ready,
        output blk_ready, ks_valid, ks_word, ks_idx, ks_last, ks_counter
    );
endinterface

// File: rtl/chacha_blk_buf.sv
// One-entry block holding register {state, counter, valid} with load and clear.
module chacha_blk_buf
    import chacha_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             clear,
    input  state_t           load_state,
    input  logic [CNT_W-1:0] load_counter,
    output state_t           state,
    output logic [CNT_W-1:0] counter,
    output logic             valid
);

    // Load wins over clear so a retiring slot can be refilled in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= '0;
            counter <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            state   <= load_state;
            counter <= load_counter;
            valid   <= 1'b1;
        end else if (clear) begin
            state   <= '0;
            counter <= '0;
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/chacha_block_serializer.sv
// Streams a 4x4 ChaCha keystream block as 16 words, with an active (A) and a
// pending (P) block buffer so consecutive blocks stream without bubbles.
module chacha_block_serializer
    import chacha_pkg::*;
#(
    parameter bit          BYTE_SWAP = 1'b0,
    parameter int unsigned CNT_W     = 32
) (
    input  logic clk,
    input  logic clr,
    input  logic flush,
    chacha_block_serializer_if.slave bus
);

    state_t           a_state, p_state, a_src_state, a_state_nxt;
    logic [CNT_W-1:0] a_counter, p_counter, a_src_counter;
    logic             a_valid, p_valid, a_valid_nxt, p_valid_nxt;
    logic             accept, fire, retire;
    logic             a_load, a_from_p, a_clear, p_load, p_clear;
    idx_t             idx_q, idx_nxt;
    logic             blk_ready_q, ks_last_q;
    word_t            ks_word_q, word_sel, ks_word_nxt;

    chacha_blk_buf #(.CNT_W(CNT_W)) u_buf_a (
        .clk          (clk),
        .clr          (clr),
        .load         (a_load),
        .clear        (a_clear),
        .load_state   (a_src_state),
        .load_counter (a_src_counter),
        .state        (a_state),
        .counter      (a_counter),
        .valid        (a_valid)
    );

    chacha_blk_buf #(.CNT_W(CNT_W)) u_buf_p (
        .clk          (clk),
        .clr          (clr),
        .load         (p_load),
        .clear        (p_clear),
        .load_state   (bus.blk_state),
        .load_counter (bus.blk_counter),
        .state        (p_state),
        .counter      (p_counter),
        .valid        (p_valid)
    );

    // Retire/promote/load sequencing; flush retires A without firing a word.
    always_comb begin
        accept        = bus.blk_valid & blk_ready_q & ~clr;
        fire          = a_valid & bus.ks_ready & ~flush;
        retire        = a_valid & (flush | (fire & (idx_q == LAST_IDX)));
        a_load        = 1'b0;
        a_from_p      = 1'b0;
        a_clear       = 1'b0;
        p_clear       = 1'b0;
        p_load        = 1'b0;
        idx_nxt       = idx_q;
        a_src_state   = bus.blk_state;
        a_src_counter = bus.blk_counter;

        if (retire) begin
            if (p_valid) begin
                a_load   = 1'b1;
                a_from_p = 1'b1;
                p_clear  = 1'b1;
            end else if (accept) begin
                a_load = 1'b1;
            end else begin
                a_clear = 1'b1;
            end
        end else if (accept && !a_valid) begin
            a_load = 1'b1;
        end
        p_load = accept & a_valid & ~retire;

        if (a_from_p) begin
            a_src_state   = p_state;
            a_src_counter = p_counter;
        end

        if (retire) begin
            idx_nxt = '0;
        end else if (fire) begin
            idx_nxt = idx_q + IDX_W'(1);
        end

        a_valid_nxt = a_load | (a_valid & ~a_clear);
        a_state_nxt = a_load ? a_src_state : a_state;
        p_valid_nxt = p_load | (p_valid & ~p_clear);
        word_sel    = state_word(a_state_nxt, idx_nxt);
        ks_word_nxt = '0;
        if (a_valid_nxt) begin
            ks_word_nxt = BYTE_SWAP ? bswap32(word_sel) : word_sel;
        end
    end

    // Output word and flags are registered from next-state so they track A/idx.
    always_ff @(posedge clk) begin
        if (clr) begin
            idx_q       <= '0;
            blk_ready_q <= 1'b0;
            ks_word_q   <= '0;
            ks_last_q   <= 1'b0;
        end else begin
            idx_q       <= idx_nxt;
            blk_ready_q <= ~p_valid_nxt;
            ks_word_q   <= ks_word_nxt;
            ks_last_q   <= a_valid_nxt & (idx_nxt == LAST_IDX);
        end
    end

    assign bus.blk_ready  = blk_ready_q;
    assign bus.ks_valid   = a_valid;
    assign bus.ks_word    = ks_word_q;
    assign bus.ks_idx     = idx_q;
    assign bus.ks_last    = ks_last_q;
    assign bus.ks_counter = a_counter;

endmodule

// File: tb/tb_chacha_block_serializer.sv
// Scoreboard bench for chacha_block_serializer: plain and byte-swapped instances in lockstep.
module tb_chacha_block_serializer;
    import chacha_pkg::*;

    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic clr;
    logic flush;
    always #5 clk = ~clk;

    chacha_block_serializer_if #(.CNT_W(CNT_W)) bus ();
    chacha_block_serializer_if #(.CNT_W(CNT_W)) sw_bus ();

    chacha_block_serializer #(.BYTE_SWAP(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .flush(flush), .bus(bus.slave)
    );
    chacha_block_serializer #(.BYTE_SWAP(1'b1), .CNT_W(CNT_W)) dut_sw (
        .clk(clk), .clr(clr), .flush(flush), .bus(sw_bus.slave)
    );

    assign sw_bus.blk_valid   = bus.blk_valid;
    assign sw_bus.blk_state   = bus.blk_state;
    assign sw_bus.blk_counter = bus.blk_counter;
    assign sw_bus.ks_ready    = bus.ks_ready;

    typedef struct {
        word_t            word;
        idx_t             idx;
        logic [CNT_W-1:0] cnt;
        logic             last;
    } exp_t;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        word_t            base;
        int               stall_at;
        int               stall_len;
        word_t            exp_first;
        word_t            exp_first_sw;
    } vec_t;

    exp_t sb[$];
    vec_t vt[3];
    int   checks   = 0;
    int   failures = 0;
    int   w1, w2, w3, run;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input logic [CNT_W-1:0] cnt, input word_t base);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.word = base + word_t'(i);
            e.idx  = idx_t'(i);
            e.cnt  = cnt;
            e.last = (i == 15);
            sb.push_back(e);
        end
    endtask

    // Offer one block until accepted; waits = cycles seen with blk_ready low.
    task automatic offer(input logic [CNT_W-1:0] cnt, input word_t base, output int waits);
        logic rdy;
        logic acc;
        acc   = 1'b0;
        waits = 0;
        bus.blk_valid   = 1'b1;
        bus.blk_counter = cnt;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.blk_state[r][c] = base + word_t'(4 * r + c);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = bus.blk_ready;
            @(posedge clk);
            if (rdy === 1'b1) begin
                acc = 1'b1;
                break;
            end
            waits++;
        end
        if (acc) push_block(cnt, base);
        else chk("accept_timeout", 64'(waits), 64'(0));
        #1;
        bus.blk_valid = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ks_valid === 1'b1 && bus.ks_idx == idx_t'(target)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) chk("wait_idx_timeout", 64'(bus.ks_idx), 64'(target));
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (sb.size() == 0 && bus.ks_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    // Scoreboard monitor: compare every fired word against the model queue.
    always @(negedge clk) begin
        if (clr === 1'b0 && flush === 1'b0 && bus.ks_valid === 1'b1 && bus.ks_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=0x%0h idx=%0d required=none", bus.ks_word, bus.ks_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ks_word",    64'(bus.ks_word),     64'(e.word));
                chk("ks_idx",     64'(bus.ks_idx),      64'(e.idx));
                chk("ks_counter", 64'(bus.ks_counter),  64'(e.cnt));
                chk("ks_last",    64'(bus.ks_last),     64'(e.last));
                chk("sw_valid",   64'(sw_bus.ks_valid), 64'(1));
                chk("sw_word",    64'(sw_bus.ks_word),  64'(bswap32(e.word)));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{cnt: 32'd7,          base: 32'hA000_0000, stall_at: 16, stall_len: 0,
                  exp_first: 32'hA000_0000, exp_first_sw: 32'h0000_00A0};
        vt[1] = '{cnt: 32'h55,         base: 32'h1234_5600, stall_at: 4,  stall_len: 3,
                  exp_first: 32'h1234_5600, exp_first_sw: 32'h0056_3412};
        vt[2] = '{cnt: 32'hFFFF_FFFF,  base: 32'hDEAD_BE00, stall_at: 0,  stall_len: 2,
                  exp_first: 32'hDEAD_BE00, exp_first_sw: 32'h00BE_ADDE};

        // Reset held 3 cycles with a block offered.
        clr = 1'b1;
        flush = 1'b0;
        bus.ks_ready = 1'b1;
        bus.blk_valid = 1'b1;
        bus.blk_counter = 32'd99;
        bus.blk_state = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", 64'(bus.ks_valid),  64'(0));
            chk("rst_idx",   64'(bus.ks_idx),    64'(0));
            chk("rst_ready", 64'(bus.blk_ready), 64'(0));
        end
        clr = 1'b0;
        bus.blk_valid = 1'b0;
        tick();
        chk("rel_ready", 64'(bus.blk_ready), 64'(1));
        chk("rel_valid", 64'(bus.ks_valid),  64'(0));

        // Table: single blocks with optional backpressure window.
        for (int v = 0; v < 3; v++) begin
            int   stalled;
            logic first_seen;
            stalled = 0;
            first_seen = 1'b0;
            bus.ks_ready = 1'b1;
            offer(vt[v].cnt, vt[v].base, w1);
            chk("latency_valid", 64'(bus.ks_valid), 64'(1));
            chk("latency_idx",   64'(bus.ks_idx),   64'(0));
            for (int i = 0; i < 60; i++) begin
                if (bus.ks_valid !== 1'b1) break;
                if (!first_seen && bus.ks_idx == 0) begin
                    first_seen = 1'b1;
                    chk("first_word",    64'(bus.ks_word),    64'(vt[v].exp_first));
                    chk("first_word_sw", 64'(sw_bus.ks_word), 64'(vt[v].exp_first_sw));
                end
                if (bus.ks_idx == idx_t'(vt[v].stall_at) && stalled < vt[v].stall_len) begin
                    bus.ks_ready = 1'b0;
                    stalled++;
                    chk("stall_idx",  64'(bus.ks_idx),  64'(vt[v].stall_at));
                    chk("stall_word", 64'(bus.ks_word), 64'(vt[v].base + word_t'(vt[v].stall_at)));
                end else begin
                    bus.ks_ready = 1'b1;
                end
                tick();
            end
            bus.ks_ready = 1'b1;
            drain();
            chk("idle_ready", 64'(bus.blk_ready), 64'(1));
        end

        // Back-to-back: three blocks, one contiguous 48-word burst.
        run = 0;
        fork
            begin
                offer(32'd1, 32'h1000_0000, w1);
                offer(32'd2, 32'h2000_0000, w2);
                chk("ready_p_full", 64'(bus.blk_ready), 64'(0));
                offer(32'd3, 32'h3000_0000, w3);
            end
            begin
                for (int i = 0; i < 20 && bus.ks_valid !== 1'b1; i++) tick();
                while (bus.ks_valid === 1'b1 && run < 100) begin
                    run++;
                    tick();
                end
            end
        join
        chk("b2b_wait2", 64'(w2),  64'(0));
        chk("b2b_wait3", 64'(w3),  64'(15));
        chk("b2b_run",   64'(run), 64'(48));
        drain();

        // Flush at idx 5 with a pending block.
        offer(32'd10, 32'h4000_0000, w1);
        offer(32'd11, 32'h5000_0000, w1);
        wait_idx(5);
        flush = 1'b1;
        while (sb.size() > 0 && sb[0].idx != 0) void'(sb.pop_front());
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(bus.ks_valid),   64'(1));
        chk("flush_idx",   64'(bus.ks_idx),     64'(0));
        chk("flush_cnt",   64'(bus.ks_counter), 64'(11));
        chk("flush_word",  64'(bus.ks_word),    64'(32'h5000_0000));
        chk("flush_ready", 64'(bus.blk_ready),  64'(1));
        drain();

        // Flush with A empty.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_empty_valid", 64'(bus.ks_valid),  64'(0));
        chk("flush_empty_idx",   64'(bus.ks_idx),    64'(0));
        chk("flush_empty_ready", 64'(bus.blk_ready), 64'(1));

        // Flush together with an accept while P is empty.
        offer(32'd20, 32'h6000_0000, w1);
        wait_idx(3);
        flush = 1'b1;
        while (sb.size() > 0 && sb[0].idx != 0) void'(sb.pop_front());
        offer(32'd21, 32'h7000_0000, w1);
        flush = 1'b0;
        chk("flush_acc_idx", 64'(bus.ks_idx),     64'(0));
        chk("flush_acc_cnt", 64'(bus.ks_counter), 64'(21));
        drain();

        // Retire at idx 15 with a block arriving the same cycle.
        offer(32'd30, 32'h8000_0000, w1);
        wait_idx(15);
        offer(32'd31, 32'h9000_0000, w1);
        chk("direct_valid", 64'(bus.ks_valid),   64'(1));
        chk("direct_idx",   64'(bus.ks_idx),     64'(0));
        chk("direct_cnt",   64'(bus.ks_counter), 64'(31));
        chk("direct_wait",  64'(w1),             64'(0));
        drain();

        // clr mid-stream at idx 9 with P full.
        offer(32'd40, 32'hB000_0000, w1);
        offer(32'd41, 32'hC000_0000, w1);
        wait_idx(9);
        clr = 1'b1;
        sb.delete();
        tick();
        chk("clr_valid", 64'(bus.ks_valid),  64'(0));
        chk("clr_idx",   64'(bus.ks_idx),    64'(0));
        chk("clr_word",  64'(bus.ks_word),   64'(0));
        chk("clr_last",  64'(bus.ks_last),   64'(0));
        chk("clr_ready", 64'(bus.blk_ready), 64'(0));
        clr = 1'b0;
        tick();
        chk("clr_rel_ready", 64'(bus.blk_ready), 64'(1));
        chk("clr_rel_valid", 64'(bus.ks_valid),  64'(0));
        for (int i = 0; i < 3; i++) tick();
        chk("clr_quiet", 64'(bus.ks_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
